puzzle_board_ctrl: RTL and testbench
====================================

Name: puzzle_board_ctrl

Overview:
- Owns the registered 3x3 sliding-puzzle board and drives the combinational move stage directly downstream of it.
- Debounces the five push buttons and converts the four direction buttons into single-cycle move pulses.
- Latches the board returned by the move stage, counts effective moves and flags the solved board.
- On btnc, scrambles the board itself with an LFSR-driven random walk, so every scrambled board is solvable.

Parameters:
- DB_CYCLES, 500000: cycles a synchronised button level must be stable before it is accepted.
- SHUFFLE_MOVES, 64: effective (board-changing) moves per shuffle; legal range 1..65535.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR (x^16+x^14+x^13+x^11+1); must be nonzero.
- MCNT_W, 10: move counter width.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- btnl, btnr, btnu, btnd, btnc, in, 1 each: raw asynchronous push buttons.
- row_in1, row_in2, row_in3, in, 12 each: next-board rows returned by the move stage.
- move_l, move_r, move_u, move_d, out, 1 each: registered one-hot move pulses to the move stage.
- Row1, Row2, Row3, out, 12 each: current board to the move stage and display.
- move_cnt, out, MCNT_W: effective player moves since the last shuffle.
- solved, out, 1: board equals solved pattern.
- busy, out, 1: high while shuffling.

Behaviour:
- Encoding: nibble 0 = blank, [11:8] = left column. Solved pattern = Row1 12'h123, Row2 12'h456, Row3 12'h780.
- Direction = blank movement. The move stage returns the board unchanged for an illegal move.
- Reset values: Row = solved pattern, move pulses 0, move_cnt 0, solved 1, busy 0, LFSR = LFSR_SEED, state IDLE, debouncers cleared.
- Reset mid-shuffle or mid-move: abandon everything; the next cycle shows the reset values.
- Button input: each button passes through a 2-FF synchroniser, then a stability counter.
- Debounced level changes only after DB_CYCLES consecutive equal samples.
- A rising edge of the debounced level raises a one-cycle request.
- Simultaneous direction requests: priority l > r > u > d. Lower-priority requests in that cycle are dropped.
- Move timing: request registered at cycle n, one move pulse high at n+1. Row <= row_in at the edge ending n+1, so the new board is visible at n+2.
- At most one pulse is outstanding. Requests arriving during a pulse cycle are dropped.
- Effective move: row_in differs from Row. Only then does move_cnt increment, saturating at all ones.
- solved: registered compare of Row, updated with Row.
- State IDLE (after reset): direction requests are accepted. An effective move goes to PLAY, or to SOLVED if the result is solved. btnc goes to SHUFFLE.
- State SHUFFLE: busy=1 and player buttons are ignored (btnc included).
  - Each cycle the LFSR advances. Every other cycle a pulse is issued on direction lfsr[1:0] (00 l, 01 r, 10 u, 11 d) and the result is latched.
  - Effective moves are counted internally up to SHUFFLE_MOVES.
  - At count: if the board is solved, restart the count. Otherwise clear move_cnt, set busy=0 and go to PLAY.
- State PLAY: direction requests are processed. An effective move producing the solved pattern goes to SOLVED. btnc goes to SHUFFLE.
- State SOLVED: solved=1 and move_cnt is frozen at its final value. Effective moves go to PLAY with the count continuing. btnc goes to SHUFFLE.

Optional Feature:
- Macro SHUFFLE_NO_BACKTRACK_EN.
- Defined: during SHUFFLE, a drawn direction that is the inverse of the previous effective shuffle move (l/r, u/d) is skipped with no pulse that slot. The LFSR still advances.
- Undefined: every drawn direction is issued.
- Player moves are unaffected in both cases.

Test Plan:
Bench instantiates the downstream move stage, with DB_CYCLES=2, SHUFFLE_MOVES=4 and default seed.
- Reset -> Row 123/456/780, move_cnt 0, solved 1, busy 0, all pulses 0.
- From reset, hold btnl 10 cycles -> exactly one move_l pulse, Row 123/456/708, move_cnt 1, solved 0. Then btnr -> Row 123/456/780, move_cnt 2, solved 1.
- btnr from the solved board -> one move_r pulse, Row unchanged, move_cnt 0.
- btnc -> busy high for at least 8 cycles, exactly 4 board-changing pulses, then busy 0, move_cnt 0, solved 0, Row nibbles a permutation of 0..8.
- btnl and btnu rising in the same cycle from the solved board -> only move_l, Row 123/456/708.
- Reset asserted mid-shuffle -> next cycle Row solved, busy 0, move_cnt 0; btnd during the shuffle produced no player pulse.

Source files
------------

// File: rtl/puzzle_board_ctrl.sv
// 3x3 sliding-puzzle board controller: button debounce, move pulses, board latch,
// move counting, solved flag and LFSR shuffle. Optional macro: SHUFFLE_NO_BACKTRACK_EN.
module puzzle_board_ctrl #(
  parameter int          DB_CYCLES     = 500000,
  parameter int          SHUFFLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          MCNT_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btnl,
  input  logic              btnr,
  input  logic              btnu,
  input  logic              btnd,
  input  logic              btnc,
  input  logic [11:0]       row_in1,
  input  logic [11:0]       row_in2,
  input  logic [11:0]       row_in3,
  output logic              move_l,
  output logic              move_r,
  output logic              move_u,
  output logic              move_d,
  output logic [11:0]       Row1,
  output logic [11:0]       Row2,
  output logic [11:0]       Row3,
  output logic [MCNT_W-1:0] move_cnt,
  output logic              solved,
  output logic              busy
);

  localparam int          CW           = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [35:0] SOLVED_BOARD = 36'h123456780;

  typedef enum logic [1:0] {IDLE, SHUFFLE, PLAY, SOLVED} state_t;

  state_t         state, state_nxt;
  logic [4:0]     btns, sync1, sync2, db_lvl, req;
  logic [CW-1:0]  db_cnt [5];
  logic [3:0]     move_q;
  logic [15:0]    lfsr, sh_cnt;
  logic [35:0]    board, board_in;
  logic           eff, eff_solved, sh_slot, sh_at_count, sh_done, skip;

  assign btns        = {btnc, btnd, btnu, btnr, btnl};
  assign board       = {Row1, Row2, Row3};
  assign board_in    = {row_in1, row_in2, row_in3};
  assign eff         = (move_q != 4'b0) && (board_in != board);
  assign eff_solved  = (board_in == SOLVED_BOARD);
  assign sh_slot     = (sh_cnt < 16'(SHUFFLE_MOVES));
  assign sh_at_count = (state == SHUFFLE) && (move_q == 4'b0) && (sh_cnt == 16'(SHUFFLE_MOVES));
  assign sh_done     = sh_at_count && !solved;

  assign move_l = move_q[0];
  assign move_r = move_q[1];
  assign move_u = move_q[2];
  assign move_d = move_q[3];

  // Level is accepted after DB_CYCLES consecutive samples differing from it;
  // a 0->1 acceptance produces a one-cycle request.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      req    <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btns;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        req[i] <= 1'b0;
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
            db_lvl[i] <= sync2[i];
            req[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef SHUFFLE_NO_BACKTRACK_EN
  logic [1:0] last_dir;
  logic       last_vld;

  // Encoding l=00 r=01 u=10 d=11, so the inverse direction differs in bit 0.
  always_ff @(posedge clk) begin
    if (reset || state != SHUFFLE) begin
      last_dir <= 2'b00;
      last_vld <= 1'b0;
    end else if (eff) begin
      last_dir <= {move_q[3] | move_q[2], move_q[3] | move_q[1]};
      last_vld <= 1'b1;
    end
  end

  assign skip = last_vld && (lfsr[1:0] == (last_dir ^ 2'b01));
`else
  assign skip = 1'b0;
`endif

  // A pulse lasts exactly one cycle; nothing new is issued while one is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_q <= '0;
    end else if (move_q != 4'b0) begin
      move_q <= '0;
    end else if (state == SHUFFLE) begin
      if (sh_slot && !skip) move_q <= 4'b0001 << lfsr[1:0];
    end else if (!req[4]) begin
      if (req[0])      move_q <= 4'b0001;
      else if (req[1]) move_q <= 4'b0010;
      else if (req[2]) move_q <= 4'b0100;
      else if (req[3]) move_q <= 4'b1000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {Row1, Row2, Row3} <= SOLVED_BOARD;
      solved   <= 1'b1;
      move_cnt <= '0;
      sh_cnt   <= '0;
      lfsr     <= LFSR_SEED;
    end else begin
      if (move_q != 4'b0) begin
        {Row1, Row2, Row3} <= board_in;
        solved             <= eff_solved;
      end
      if (state == SHUFFLE) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state != SHUFFLE) begin
        sh_cnt <= '0;
        if (eff && move_cnt != '1) move_cnt <= move_cnt + 1'b1;
      end else if (eff) begin
        sh_cnt <= sh_cnt + 16'd1;
      end else if (sh_at_count) begin
        // A walk that lands back on the solved board is simply continued.
        if (solved) sh_cnt   <= '0;
        else        move_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req[4])   state_nxt = SHUFFLE;
        else if (eff) state_nxt = eff_solved ? SOLVED : PLAY;
      end
      PLAY: begin
        if (req[4])                  state_nxt = SHUFFLE;
        else if (eff && eff_solved)  state_nxt = SOLVED;
      end
      SOLVED: begin
        if (req[4])   state_nxt = SHUFFLE;
        else if (eff) state_nxt = PLAY;
      end
      SHUFFLE: begin
        if (sh_done) state_nxt = PLAY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHUFFLE);
  end

endmodule

// File: tb/tb_puzzle_board_ctrl.sv
// Bench for puzzle_board_ctrl with a behavioural move stage and a pulse scoreboard.
module tb_puzzle_board_ctrl;

  localparam int W = 51;  // {dir[3:0], board[35:0], move_cnt[9:0], solved}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0, btnc = 1'b0;
  logic [11:0] row_in1, row_in2, row_in3;
  logic        move_l, move_r, move_u, move_d;
  logic [11:0] Row1, Row2, Row3;
  logic [9:0]  move_cnt;
  logic        solved, busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic        pl_pend = 1'b0;
  logic        sh_pend = 1'b0;
  logic [3:0]  pl_dir;
  logic [35:0] sh_prev;
  int          sh_eff = 0;
  int          pl_cnt [4] = '{0, 0, 0, 0};

  puzzle_board_ctrl #(
    .DB_CYCLES(2), .SHUFFLE_MOVES(4), .LFSR_SEED(16'hACE1), .MCNT_W(10)
  ) dut (
    .clk(clk), .reset(reset),
    .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd), .btnc(btnc),
    .row_in1(row_in1), .row_in2(row_in2), .row_in3(row_in3),
    .move_l(move_l), .move_r(move_r), .move_u(move_u), .move_d(move_d),
    .Row1(Row1), .Row2(Row2), .Row3(Row3),
    .move_cnt(move_cnt), .solved(solved), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream move stage: moves the blank, returns the board unchanged if illegal.
  function automatic logic [35:0] move_stage(input logic [35:0] b, input logic [3:0] mv);
    logic [35:0] nb;
    int p, r, c, t;
    nb = b;
    p = 0;
    for (int k = 0; k < 9; k++) if (b[35-4*k -: 4] == 4'h0) p = k;
    r = p / 3;
    c = p % 3;
    t = -1;
    if (mv[0] && c > 0)      t = p - 1;
    else if (mv[1] && c < 2) t = p + 1;
    else if (mv[2] && r > 0) t = p - 3;
    else if (mv[3] && r < 2) t = p + 3;
    if (t >= 0) begin
      nb[35-4*p -: 4] = b[35-4*t -: 4];
      nb[35-4*t -: 4] = 4'h0;
    end
    return nb;
  endfunction

  always_comb begin
    {row_in1, row_in2, row_in3} = move_stage({Row1, Row2, Row3}, {move_d, move_u, move_r, move_l});
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_move(input logic [3:0] dir, input logic [35:0] b, input logic [9:0] cnt,
                             input logic slv);
    exp_q.push_back({dir, b, cnt, slv});
  endtask

  // Called once per falling edge: scores player pulses and counts shuffle moves.
  task automatic sample();
    logic [3:0]   p;
    logic [W-1:0] e;
    p = {move_d, move_u, move_r, move_l};
    if (reset) begin
      pl_pend = 1'b0;
      sh_pend = 1'b0;
      return;
    end
    if (sh_pend) begin
      if ({Row1, Row2, Row3} != sh_prev) sh_eff++;
      sh_pend = 1'b0;
    end
    if (pl_pend) begin
      check_eq("pulse_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("pulse_dir", pl_dir, e[50:47]);
        check_eq("board", {Row1, Row2, Row3}, e[46:11]);
        check_eq("move_cnt", move_cnt, e[10:1]);
        check_eq("solved", solved, e[0]);
      end
      pl_pend = 1'b0;
    end
    if (p != 4'b0) begin
      check_eq("pulse_onehot", $countones(p), 1);
      if (busy) begin
        sh_pend = 1'b1;
        sh_prev = {Row1, Row2, Row3};
      end else begin
        pl_pend = 1'b1;
        pl_dir  = p;
        for (int i = 0; i < 4; i++) if (p[i]) pl_cnt[i]++;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btnc, btnd, btnu, btnr, btnl} = m;
  endtask

  task automatic press(input logic [4:0] m, input int hold, input int idle);
    set_btns(m);
    run_cycles(hold);
    set_btns(5'b0);
    run_cycles(idle);
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pl_pend = 1'b0;
    sh_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_busy_rise(input string tag);
    int n;
    n = 0;
    while (!busy && n < 40) begin
      run_cycles(1);
      n++;
    end
    check_eq(tag, busy, 1);
  endtask

  initial begin
    int snap [4];
    int n;
    logic [8:0]  mask;
    logic [35:0] b;

    do_reset();
    check_eq("rst_row1", Row1, 12'h123);
    check_eq("rst_row2", Row2, 12'h456);
    check_eq("rst_row3", Row3, 12'h780);
    check_eq("rst_move_cnt", move_cnt, 0);
    check_eq("rst_solved", solved, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", {move_d, move_u, move_r, move_l}, 0);

    // Held left then right: blank goes out and back.
    snap = pl_cnt;
    expect_move(4'b0001, 36'h123456708, 10'd1, 1'b0);
    press(5'b00001, 10, 12);
    check_eq("move_l_pulses", pl_cnt[0] - snap[0], 1);
    expect_move(4'b0010, 36'h123456780, 10'd2, 1'b1);
    press(5'b00010, 10, 12);
    check_eq("move_r_pulses", pl_cnt[1] - snap[1], 1);
    check_eq("exp_q_drained_lr", exp_q.size(), 0);

    // Illegal move from solved board.
    do_reset();
    snap = pl_cnt;
    expect_move(4'b0010, 36'h123456780, 10'd0, 1'b1);
    press(5'b00010, 10, 12);
    check_eq("illegal_r_pulses", pl_cnt[1] - snap[1], 1);
    check_eq("exp_q_drained_ill", exp_q.size(), 0);

    // Shuffle.
    do_reset();
    sh_eff = 0;
    snap = pl_cnt;
    set_btns(5'b10000);
    wait_busy_rise("busy_rise");
    set_btns(5'b0);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      run_cycles(1);
    end
    check_eq("busy_fall", busy, 0);
    check_eq("busy_len_ge8", 64'(n >= 8), 1);
    check_eq("shuffle_eff_mult4", sh_eff % 4, 0);
    check_eq("shuffle_eff_min4", 64'(sh_eff >= 4), 1);
    check_eq("shuf_move_cnt", move_cnt, 0);
    check_eq("shuf_solved", solved, 0);
    b = {Row1, Row2, Row3};
    mask = '0;
    for (int k = 0; k < 9; k++) if (b[35-4*k -: 4] <= 4'd8) mask[b[35-4*k -: 4]] = 1'b1;
    check_eq("shuf_permutation", mask, 9'h1FF);
    check_eq("shuf_no_player_pulse", (pl_cnt[0] + pl_cnt[1] + pl_cnt[2] + pl_cnt[3])
             - (snap[0] + snap[1] + snap[2] + snap[3]), 0);
    run_cycles(4);
    check_eq("shuf_busy_stays_low", busy, 0);

    // Left and up rising together: left wins, up dropped.
    do_reset();
    snap = pl_cnt;
    expect_move(4'b0001, 36'h123456708, 10'd1, 1'b0);
    press(5'b00101, 10, 12);
    check_eq("prio_l_pulses", pl_cnt[0] - snap[0], 1);
    check_eq("prio_u_pulses", pl_cnt[2] - snap[2], 0);
    check_eq("exp_q_drained_prio", exp_q.size(), 0);

    // Reset in the middle of a shuffle with btnd pressed meanwhile.
    do_reset();
    snap = pl_cnt;
    set_btns(5'b10000);
    wait_busy_rise("busy_rise2");
    set_btns(5'b01000);
    run_cycles(3);
    set_btns(5'b0);
    check_eq("busy_mid_shuffle", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_board", {Row1, Row2, Row3}, 36'h123456780);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_move_cnt", move_cnt, 0);
    check_eq("midrst_solved", solved, 1);
    check_eq("midrst_pulses", {move_d, move_u, move_r, move_l}, 0);
    reset = 1'b0;
    pl_pend = 1'b0;
    sh_pend = 1'b0;
    run_cycles(20);
    check_eq("midrst_no_d_pulse", pl_cnt[3] - snap[3], 0);
    check_eq("midrst_idle_busy", busy, 0);
    check_eq("exp_q_drained_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
